// File: rtl/alu_result_buffer.sv
// Two-entry result FIFO between the ALU and the next stage, with sticky overflow tracking.
// One-cycle latency; in_ready and out_* depend on registered state only, never on out_ready or in_*.
module alu_result_buffer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_result,
  input  logic             in_zero,
  input  logic             in_cout,
  input  logic             in_overflow,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic             out_zero,
  output logic             out_cout,
  output logic             out_overflow,
  output logic [3:0]       out_op,
  input  logic             clear_ovf,
  output logic             ovf_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        cout;
    logic        overflow;
    logic [3:0]  op;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           in_entry;
  entry_t           head;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             sticky_q, sticky_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  assign in_ready  = (occ_q != 2'd2);
  assign out_valid = (occ_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign in_entry = '{result: in_result, zero: in_zero, cout: in_cout,
                      overflow: in_overflow, op: in_op};

  assign head         = mem_q[rd_ptr_q];
  assign out_result   = head.result;
  assign out_zero     = head.zero;
  assign out_cout     = head.cout;
  assign out_overflow = head.overflow;
  assign out_op       = head.op;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // A qualifying overflow push wins over clear: the cleared counter restarts at 1.
  always_comb begin
    sticky_d = sticky_q;
    cnt_d    = cnt_q;
    if (push && in_overflow) begin
      sticky_d = 1'b1;
      if (clear_ovf)        cnt_d = CNT_W'(1);
      else if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end else if (clear_ovf) begin
      sticky_d = 1'b0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push) mem_q[wr_ptr_q] <= in_entry;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sticky_q <= sticky_d;
      cnt_q    <= cnt_d;
    end
  end

  assign ovf_sticky = sticky_q;
  assign ovf_count  = cnt_q;

endmodule

// File: tb/tb_alu_result_buffer.sv
// Scoreboard bench for alu_result_buffer: the driver queues expected entries on acceptance,
// a negedge monitor pops and compares on every output handshake and checks hold stability.
module tb_alu_result_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_result;
  logic        in_zero, in_cout, in_overflow;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_zero, out_cout, out_overflow;
  logic [3:0]  out_op;
  logic        clear_ovf;
  logic        ovf_sticky;
  logic [7:0]  ovf_count;

  int checks   = 0;
  int failures = 0;

  logic [38:0] exp_q[$];

  alu_result_buffer #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
    .in_zero(in_zero), .in_cout(in_cout), .in_overflow(in_overflow), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_zero(out_zero), .out_cout(out_cout), .out_overflow(out_overflow), .out_op(out_op),
    .clear_ovf(clear_ovf), .ovf_sticky(ovf_sticky), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push_item(input logic [31:0] r, input logic z, input logic c,
                           input logic o, input logic [3:0] op);
    bit accepted = 1'b0;
    in_valid = 1'b1; in_result = r; in_zero = z; in_cout = c; in_overflow = o; in_op = op;
    for (int i = 0; i < 200 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
    end
    if (accepted) exp_q.push_back({r, z, c, o, op});
    else begin
      checks++; failures++;
      $display("FAIL push_timeout: in_ready stayed 0 for data 0x%0h", r);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_cout = 1'b0; in_overflow = 1'b0; in_op = '0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL drain_timeout: %0d entries still expected", exp_q.size());
    end
    @(posedge clk); #1;
  endtask

  // Monitor: compare each popped head against the scoreboard, and check hold stability.
  logic        hold_prev = 1'b0;
  logic [38:0] held;
  initial begin
    logic [38:0] cur;
    logic [38:0] exp;
    forever begin
      @(negedge clk);
      cur = {out_result, out_zero, out_cout, out_overflow, out_op};
      if (hold_prev && out_valid && !rst) check("hold_stable", 64'(cur), 64'(held));
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_output: got 0x%0h with empty scoreboard", cur);
        end else begin
          exp = exp_q.pop_front();
          check("out_entry", 64'(cur), 64'(exp));
        end
      end
      hold_prev = out_valid && !out_ready && !rst;
      held      = cur;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_result = '0; in_zero = 1'b0; in_cout = 1'b0;
    in_overflow = 1'b0; in_op = '0; out_ready = 1'b0; clear_ovf = 1'b0;

    // Reset state, defined from the first reset edge
    @(posedge clk); #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_sticky", 64'(ovf_sticky), 64'd0);
    check("rst_count", 64'(ovf_count), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single push, one-cycle latency, then empty after the pop
    out_ready = 1'b1;
    push_item(32'h0000_0005, 1'b0, 1'b0, 1'b0, 4'b0010);
    check("lat_out_valid", 64'(out_valid), 64'd1);
    check("lat_out_result", 64'(out_result), 64'h5);
    check("lat_out_op", 64'(out_op), 64'h2);
    @(posedge clk); #1;
    check("after_pop_valid", 64'(out_valid), 64'd0);

    // Fill with out_ready low, third push held until downstream drains
    out_ready = 1'b0;
    push_item(32'h1, 1'b0, 1'b1, 1'b0, 4'b0000);
    push_item(32'h2, 1'b1, 1'b0, 1'b0, 4'b0001);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head", 64'(out_result), 64'h1);
    fork
      push_item(32'h3, 1'b0, 1'b0, 1'b0, 4'b0110);
      begin
        repeat (3) @(negedge clk);
        check("held_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Streaming at occupancy 1: push and pop every cycle
    out_ready = 1'b0;
    push_item(32'h100, 1'b0, 1'b0, 1'b0, 4'b0111);
    out_ready = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      push_item(32'h100 + 32'(i), 1'(i & 1), 1'(i >> 1), 1'b0, 4'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
      check("stream_out_valid", 64'(out_valid), 64'd1);
    end
    drain();

    // Counter saturation over 300 overflowing pushes
    for (int i = 0; i < 300; i++) begin
      push_item(32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b0010);
      if (i == 9) check("count_10", 64'(ovf_count), 64'd10);
    end
    check("sat_count", 64'(ovf_count), 64'd255);
    check("sat_sticky", 64'(ovf_sticky), 64'd1);
    clear_ovf = 1'b1;
    @(posedge clk); #1;
    clear_ovf = 1'b0;
    check("clear_count", 64'(ovf_count), 64'd0);
    check("clear_sticky", 64'(ovf_sticky), 64'd0);
    drain();

    // Clear coinciding with an overflowing push
    for (int i = 0; i < 3; i++) push_item(32'h8000_0000, 1'b0, 1'b0, 1'b1, 4'b0010);
    check("pre_clear_count", 64'(ovf_count), 64'd3);
    clear_ovf = 1'b1;
    push_item(32'h8000_0001, 1'b0, 1'b1, 1'b1, 4'b0010);
    clear_ovf = 1'b0;
    check("clr_push_count", 64'(ovf_count), 64'd1);
    check("clr_push_sticky", 64'(ovf_sticky), 64'd1);
    drain();

    // Reset while full with a push pending
    out_ready = 1'b0;
    push_item(32'hA, 1'b0, 1'b0, 1'b1, 4'b0011);
    push_item(32'hB, 1'b0, 1'b0, 1'b1, 4'b0100);
    check("pre_rst_count", 64'(ovf_count), 64'd3);
    check("pre_rst_in_ready", 64'(in_ready), 64'd0);
    in_valid = 1'b1; in_result = 32'hC; in_overflow = 1'b1; in_op = 4'b0101;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0; in_result = '0; in_overflow = 1'b0; in_op = '0;
    exp_q.delete();
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd1);
    check("mid_rst_count", 64'(ovf_count), 64'd0);
    check("mid_rst_sticky", 64'(ovf_sticky), 64'd0);
    check("mid_rst_out_result", 64'(out_result), 64'd0);
    @(posedge clk); #1;
    check("discarded_valid", 64'(out_valid), 64'd0);

    // Normal operation after reset
    out_ready = 1'b1;
    push_item(32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 4'b1111);
    drain();
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
